// File: rtl/pixel_readback_buffer.sv
// Shadow copy of the 160x120 plot screen with a 1-cycle colour read port.
// A full-screen clear sweep runs after reset and on clr_start; reads and writes are held off meanwhile.
module pixel_readback_buffer #(
  parameter int         WIDTH     = 160,
  parameter int         HEIGHT    = 120,
  parameter logic [2:0] BG_COLOUR = 3'b000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] x_in,
  input  logic [6:0] y_in,
  input  logic [2:0] colour_in,
  input  logic       plot,
  input  logic       rd_req,
  input  logic [7:0] rd_x,
  input  logic [6:0] rd_y,
  output logic       rd_valid,
  output logic [2:0] rd_colour,
  output logic       ready,
  input  logic       clr_start
);

  localparam int DEPTH = WIDTH * HEIGHT;
  localparam int AW    = $clog2(DEPTH);

  typedef enum logic {CLEAR, IDLE} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] clr_addr_q, clr_addr_d;
  logic          rd_valid_q, rd_valid_d;
  logic          rd_oor_q, rd_oor_d;
  logic          ready_q, ready_d;

  logic [2:0]    mem [DEPTH];
  logic [2:0]    mem_rd_data;

  logic          wr_en, rd_en;
  logic [AW-1:0] wr_addr, rd_addr, plot_addr;
  logic [2:0]    wr_data;
  logic          plot_in_range, rd_in_range;

  assign plot_in_range = (int'(x_in) < WIDTH) && (int'(y_in) < HEIGHT);
  assign rd_in_range   = (int'(rd_x) < WIDTH) && (int'(rd_y) < HEIGHT);
  assign plot_addr     = AW'(int'(y_in) * WIDTH + int'(x_in));
  assign rd_addr       = AW'(int'(rd_y) * WIDTH + int'(rd_x));

  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    rd_valid_d = 1'b0;
    rd_oor_d   = rd_oor_q;
    wr_en      = 1'b0;
    wr_addr    = clr_addr_q;
    wr_data    = BG_COLOUR;
    rd_en      = 1'b0;
    case (state_q)
      CLEAR: begin
        wr_en = 1'b1;
        if (clr_addr_q == AW'(DEPTH - 1)) state_d = IDLE;
        else clr_addr_d = clr_addr_q + AW'(1);
      end
      IDLE: begin
        // A clear request swallows any plot or read arriving alongside it.
        if (clr_start) begin
          state_d    = CLEAR;
          clr_addr_d = '0;
        end else begin
          if (plot && plot_in_range) begin
            wr_en   = 1'b1;
            wr_addr = plot_addr;
            wr_data = colour_in;
          end
          if (rd_req) begin
            rd_valid_d = 1'b1;
            rd_oor_d   = !rd_in_range;
            rd_en      = rd_in_range;
          end
        end
      end
      default: state_d = CLEAR;
    endcase
    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= CLEAR;
      clr_addr_q <= '0;
      rd_valid_q <= 1'b0;
      rd_oor_q   <= 1'b1;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
      rd_valid_q <= rd_valid_d;
      rd_oor_q   <= rd_oor_d;
      ready_q    <= ready_d;
    end
  end

  // Plain synchronous RAM; the read samples the old word when it collides with a write.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) mem_rd_data <= mem[rd_addr];
  end

  assign rd_valid  = rd_valid_q;
  assign rd_colour = rd_oor_q ? BG_COLOUR : mem_rd_data;
  assign ready     = ready_q;

endmodule

// File: tb/tb_pixel_readback_buffer.sv
// Self-checking bench for pixel_readback_buffer: a pixel-array model checked every cycle,
// plus directed reads with literal expected colours.
module tb_pixel_readback_buffer;

  localparam int         WIDTH  = 160;
  localparam int         HEIGHT = 120;
  localparam int         DEPTH  = WIDTH * HEIGHT;
  localparam logic [2:0] BG     = 3'b000;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] x_in, rd_x;
  logic [6:0] y_in, rd_y;
  logic [2:0] colour_in;
  logic       plot, rd_req, clr_start;
  logic       rd_valid, ready;
  logic [2:0] rd_colour;

  int  check_count = 0;
  int  pass_count  = 0;
  bit  chk_en      = 1'b0;

  logic [2:0] model_mem [DEPTH];
  int         clear_left  = DEPTH;
  logic       exp_valid   = 1'b0;
  logic [2:0] exp_colour  = BG;

  pixel_readback_buffer dut (
    .clk(clk), .rst(rst), .x_in(x_in), .y_in(y_in), .colour_in(colour_in), .plot(plot),
    .rd_req(rd_req), .rd_x(rd_x), .rd_y(rd_y), .rd_valid(rd_valid), .rd_colour(rd_colour),
    .ready(ready), .clr_start(clr_start)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    check_count++;
    if (actual == expected) pass_count++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  function automatic bit inRange(input int x, input int y);
    return (x < WIDTH) && (y < HEIGHT);
  endfunction

  // Screen model: a clear wipes the whole picture at once and then blocks traffic for DEPTH cycles.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      clear_left = DEPTH;
      exp_valid  = 1'b0;
      exp_colour = BG;
      foreach (model_mem[i]) model_mem[i] = BG;
    end else if (clear_left > 0) begin
      clear_left--;
      exp_valid = 1'b0;
    end else if (clr_start) begin
      clear_left = DEPTH;
      exp_valid  = 1'b0;
      foreach (model_mem[i]) model_mem[i] = BG;
    end else begin
      exp_valid = rd_req;
      if (rd_req)
        exp_colour = inRange(int'(rd_x), int'(rd_y)) ? model_mem[int'(rd_y) * WIDTH + int'(rd_x)] : BG;
      if (plot && inRange(int'(x_in), int'(y_in)))
        model_mem[int'(y_in) * WIDTH + int'(x_in)] = colour_in;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      checkOutput("cyc_ready", int'(ready), int'(clear_left == 0));
      checkOutput("cyc_rd_valid", int'(rd_valid), int'(exp_valid));
      checkOutput("cyc_rd_colour", int'(rd_colour), int'(exp_colour));
    end
  end

  // Drives one cycle of inputs from a negedge and returns to idle strobes at the next negedge.
  task automatic applyStimulus(input bit p, input int px, input int py, input int pc,
                               input bit r, input int rx, input int ry, input bit c);
    plot = p; x_in = 8'(px); y_in = 7'(py); colour_in = 3'(pc);
    rd_req = r; rd_x = 8'(rx); rd_y = 7'(ry); clr_start = c;
    @(negedge clk);
    plot = 1'b0; rd_req = 1'b0; clr_start = 1'b0;
  endtask

  task automatic readPixel(input string name, input int x, input int y, input int expected);
    applyStimulus(1'b0, 0, 0, 0, 1'b1, x, y, 1'b0);
    checkOutput({name, "_valid"}, int'(rd_valid), 1);
    checkOutput({name, "_colour"}, int'(rd_colour), expected);
  endtask

  task automatic countSweep(input string name);
    int n = 0;
    while (!ready && n < 20000) begin
      n++;
      @(negedge clk);
    end
    checkOutput(name, n, DEPTH);
  endtask

  initial begin
    rst = 1'b1;
    plot = 1'b0; rd_req = 1'b0; clr_start = 1'b0;
    x_in = '0; y_in = '0; colour_in = '0; rd_x = '0; rd_y = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    checkOutput("reset_ready", int'(ready), 0);
    checkOutput("reset_rd_valid", int'(rd_valid), 0);
    checkOutput("reset_rd_colour", int'(rd_colour), 0);

    // Interrupt the first sweep halfway; the sweep must start over.
    rst = 1'b0;
    repeat (9600) @(negedge clk);
    checkOutput("mid_sweep_ready", int'(ready), 0);
    @(posedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    countSweep("sweep_after_reset");

    readPixel("rd_0_0", 0, 0, 0);
    readPixel("rd_159_119", 159, 119, 0);
    readPixel("rd_80_60", 80, 60, 0);

    applyStimulus(1'b1, 10, 20, 3'b101, 1'b0, 0, 0, 1'b0);
    readPixel("rd_10_20", 10, 20, 3'b101);
    readPixel("rd_11_20", 11, 20, 0);

    applyStimulus(1'b1, 5, 5, 3'b011, 1'b1, 5, 5, 1'b0);
    checkOutput("rbw_valid", int'(rd_valid), 1);
    checkOutput("rbw_old_colour", int'(rd_colour), 0);
    readPixel("rd_5_5_new", 5, 5, 3'b011);

    applyStimulus(1'b1, 160, 0, 3'b111, 1'b0, 0, 0, 1'b0);
    applyStimulus(1'b1, 0, 120, 3'b111, 1'b0, 0, 0, 1'b0);
    readPixel("rd_159_0", 159, 0, 0);
    readPixel("rd_0_119", 0, 119, 0);
    readPixel("rd_0_0_after_oor", 0, 0, 0);
    readPixel("rd_200_100", 200, 100, 0);

    applyStimulus(1'b1, 30, 30, 3'b001, 1'b0, 0, 0, 1'b0);
    applyStimulus(1'b1, 100, 50, 3'b110, 1'b0, 0, 0, 1'b0);
    readPixel("rd_100_50", 100, 50, 3'b110);

    // Clear together with a plot; keep a read request up for the whole sweep.
    applyStimulus(1'b1, 1, 1, 3'b010, 1'b0, 0, 0, 1'b1);
    checkOutput("clr_ready_drop", int'(ready), 0);
    rd_req = 1'b1; rd_x = 8'd30; rd_y = 7'd30;
    countSweep("sweep_after_clr");
    rd_req = 1'b0;
    readPixel("clr_30_30", 30, 30, 0);
    readPixel("clr_100_50", 100, 50, 0);
    readPixel("clr_1_1", 1, 1, 0);
    readPixel("clr_10_20", 10, 20, 0);
    readPixel("clr_5_5", 5, 5, 0);

    // Reset lands just after a read result has been registered.
    applyStimulus(1'b1, 10, 20, 3'b101, 1'b0, 0, 0, 1'b0);
    rd_req = 1'b1; rd_x = 8'd10; rd_y = 7'd20;
    @(posedge clk);
    #2 rst = 1'b1;
    rd_req = 1'b0;
    @(negedge clk);
    checkOutput("pending_rd_valid", int'(rd_valid), 0);
    @(negedge clk);
    rst = 1'b0;
    countSweep("sweep_after_pending_reset");
    readPixel("final_10_20", 10, 20, 0);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule

// File: doc/pixel_readback_buffer.md
Name: pixel_readback_buffer

Overview:
- Responder for the snake backend's pixel-plot stream: accepts x/y/colour/plot writes and answers colour reads.
- Keeps a 3-bit shadow copy of the 160x120 screen, so the movement FSM's colour input reflects what was drawn.
- The backend uses the returned colour for food and collision checks.
- Sits beside the VGA adapter and receives the same plot bus, so no VGA-memory readback is needed.

Parameters:
- WIDTH, 160, screen width in pixels; x range 0..WIDTH-1.
- HEIGHT, 120, screen height in pixels; y range 0..HEIGHT-1.
- BG_COLOUR, 3'b000, colour written by the clear sweep and returned for out-of-range reads.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- x_in  in  8  write x coordinate.
- y_in  in  7  write y coordinate.
- colour_in  in  3  write colour.
- plot  in  1  write strobe; one write per high cycle.
- rd_req  in  1  read request; one read per high cycle.
- rd_x  in  8  read x coordinate.
- rd_y  in  7  read y coordinate.
- rd_valid  out  1  pulses 1 cycle; rd_colour is valid in that cycle.
- rd_colour  out  3  read result, held until the next rd_valid.
- ready  out  1  high when idle; low during the clear sweep.
- clr_start  in  1  1-cycle pulse; starts a full-screen clear.

Behaviour:
- Storage: WIDTH*HEIGHT x 3-bit memory. Address = y*WIDTH + x; for defaults, (y<<7)+(y<<5)+x, 15-bit, max 19199.
- Reset: rst high forces state CLEAR, clear address 0, rd_valid=0, rd_colour=BG_COLOUR, ready=0. Memory contents are not reset directly; they are overwritten by the sweep.
- FSM states: CLEAR, IDLE.
- CLEAR:
  - Each cycle writes BG_COLOUR at the clear address, then increments it.
  - After writing address WIDTH*HEIGHT-1, go to IDLE next cycle. Sweep length is exactly WIDTH*HEIGHT cycles (19200 for defaults).
  - plot and rd_req are ignored: no write, no rd_valid.
  - clr_start is ignored.
- IDLE:
  - ready=1.
  - clr_start=1 -> CLEAR with address 0; ready drops the next cycle. clr_start has priority over plot and rd_req in the same cycle; both are dropped.
- Writes: in IDLE with plot=1 and x_in<WIDTH and y_in<HEIGHT, memory[addr] <= colour_in at the clock edge. Out-of-range writes are silently dropped.
- Reads: in IDLE with rd_req=1 in cycle N, rd_valid=1 and rd_colour are presented in cycle N+1. Fixed latency 1, no backpressure; back-to-back requests give back-to-back results.
- Out-of-range reads (rd_x>=WIDTH or rd_y>=HEIGHT) still produce rd_valid, with rd_colour=BG_COLOUR.
- Same-address read and write in the same cycle: read returns the old contents (read-before-write). A read in the following cycle returns the new colour.
- Simultaneous read and write to different addresses: both complete; no interaction.
- rst asserted mid-sweep or mid-read: any pending rd_valid is cancelled (rd_valid=0) and the sweep restarts from address 0.
- Memory is single-write/single-read and synchronous, suitable for block-RAM inference. No combinational path from the read inputs to rd_colour.

Test Plan:
- Reset then release: ready=0 for exactly 19200 cycles, then 1. Reads at (0,0), (159,119) and (80,60) each return 3'b000 one cycle after request.
- IDLE: plot (10,20) colour 3'b101; next cycle rd_req (10,20) -> rd_valid after 1 cycle with rd_colour=3'b101. Neighbour (11,20) reads 3'b000.
- Same cycle: plot (5,5)=3'b011 and rd_req (5,5) -> returns old 3'b000. rd_req (5,5) one cycle later -> 3'b011.
- Out-of-range plot (160,0)=3'b111 and (0,120)=3'b111: reads of (159,0), (0,119) and (0,0) all stay 3'b000. rd_req (200,100) -> rd_valid with 3'b000.
- Fill several pixels, pulse clr_start together with plot (1,1)=3'b010: ready low 19200 cycles, rd_req during the sweep produces no rd_valid, and all pixels read 3'b000 afterwards.
- Assert rst halfway through a sweep and while a read result is pending: rd_valid stays 0, and ready returns exactly 19200 cycles after rst deasserts.
